// File: rtl/instr_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for instr_sequencer.
// Optional feature macro: ILLEGAL_TRAP_EN (see instr_sequencer.sv).
package instr_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RS_MSB   = 8;
  localparam int RS_LSB   = 6;
  localparam int RT_MSB   = 5;
  localparam int RT_LSB   = 3;
  localparam int FN_MSB   = 2;
  localparam int FN_LSB   = 0;
  localparam int IMM9_MSB = 8;
  localparam int IMM8_MSB = 7;

  function automatic logic [3:0] getOp(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  // Opcodes 5..E have no defined meaning.
  function automatic logic isUndefinedOp(input logic [3:0] op);
    return (op >= 4'h5) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer and its neighbours: instruction ROM, register file and ALU.
// Optional feature macro: ILLEGAL_TRAP_EN (affects the top module only).
interface instr_sequencer_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);

  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_data;
  logic [31:0]     alu_result;
  logic [2:0]      alu_op;
  logic [2:0]      waddr;
  logic [2:0]      raddr1;
  logic [2:0]      raddr2;
  logic            sto;
  logic [31:0]     wb_data;

  modport master (
    output imem_addr, alu_op, waddr, raddr1, raddr2, sto, wb_data,
    input  imem_data, alu_result
  );

  modport slave (
    input  imem_addr, alu_op, waddr, raddr1, raddr2, sto, wb_data,
    output imem_data, alu_result
  );

endinterface

// File: rtl/instr_sequencer_decode.sv
// Combinational decode of (state, ir) into register-file and ALU controls.
// Optional feature macro: ILLEGAL_TRAP_EN (no effect here; trapped opcodes never reach EXEC).
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [1:0]  state_i,
  input  logic [15:0] ir_i,
  input  logic [31:0] alu_result_i,
  output logic [2:0]  alu_op_o,
  output logic [2:0]  waddr_o,
  output logic [2:0]  raddr1_o,
  output logic [2:0]  raddr2_o,
  output logic        sto_o,
  output logic [31:0] wb_data_o
);

  // The register file writes every clock, so any cycle without a real write
  // must leave the controls at zero: r0 is copied onto itself.
  always_comb begin
    alu_op_o  = 3'd0;
    waddr_o   = 3'd0;
    raddr1_o  = 3'd0;
    raddr2_o  = 3'd0;
    sto_o     = 1'b0;
    wb_data_o = 32'd0;
    if (state_i == S_EXEC) begin
      case (getOp(ir_i))
        OP_MOV: begin
          raddr1_o = ir_i[RS_MSB:RS_LSB];
          waddr_o  = ir_i[RD_MSB:RD_LSB];
        end
        OP_LDI: begin
          waddr_o   = ir_i[RD_MSB:RD_LSB];
          sto_o     = 1'b1;
          wb_data_o = {23'd0, ir_i[IMM9_MSB:0]};
        end
        OP_ALU: begin
          raddr1_o  = ir_i[RS_MSB:RS_LSB];
          raddr2_o  = ir_i[RT_MSB:RT_LSB];
          alu_op_o  = ir_i[FN_MSB:FN_LSB];
          waddr_o   = ir_i[RD_MSB:RD_LSB];
          sto_o     = 1'b1;
          wb_data_o = alu_result_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Two-cycle fetch/execute sequencer driving an 8x32 register file that writes every clock.
// Optional feature macro: ILLEGAL_TRAP_EN -- undefined opcodes halt and raise a sticky illegal_o.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              IW       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  instr_sequencer_if.master bus,
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            illegal_o
`endif
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
`ifdef ILLEGAL_TRAP_EN
  logic            illegal_q, illegal_d;
`endif

  // JMP overrides the increment taken at FETCH; HALT is only left through reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d = bus.imem_data;
        pc_d = pc_q + 1'b1;
        if (getOp(bus.imem_data) == OP_HALT) begin
          state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
        end else if (isUndefinedOp(getOp(bus.imem_data))) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (getOp(ir_q) == OP_JMP) pc_d = PC_W'(ir_q[IMM8_MSB:0]);
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  instr_decode u_decode (
    .state_i      (state_q),
    .ir_i         (ir_q),
    .alu_result_i (bus.alu_result),
    .alu_op_o     (bus.alu_op),
    .waddr_o      (bus.waddr),
    .raddr1_o     (bus.raddr1),
    .raddr2_o     (bus.raddr2),
    .sto_o        (bus.sto),
    .wb_data_o    (bus.wb_data)
  );

  assign bus.imem_addr = pc_q;
  assign pc_o          = pc_q;
  assign halted_o      = (state_q == S_HALT);
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o     = illegal_q;
`endif

endmodule
